sn76489_reg_decoder: RTL and testbench
======================================

// Module: sn76489_reg_decoder
// PURPOSE
//   Host-side write port of the PSG: accepts SN76489-format command bytes and decodes them into the
//   register file (3 tone periods, 4 attenuations, 1 noise control) that drives the tone/noise generators.
//   Models the chip's READY behaviour with a busy window after every accepted byte.
//   Sits between the top-level byte inputs and the tone/noise/mixer blocks.
// PARAMETERS
//   TONE_FREQUENCY_BITS  10  tone period width; protocol fixes this at 10 (4 latch bits + 6 data bits)
//   ATTENUATION_BITS     4   attenuation width per channel; 4'hF = silent
//   NOISE_CONTROL_BITS   3   noise register width {fb, rate[1:0]}
//   BUSY_CYCLES          32  cycles wr_ready stays low after an accepted byte; range 0..255
// PORTS
//   clk          in   1    single clock
//   rst_n        in   1    asynchronous, active-low reset
//   wr_data      in   8    command byte
//   wr_valid     in   1    host presents wr_data; must hold until accepted
//   wr_ready     out  1    decoder can accept; byte accepted on cycle with wr_valid & wr_ready
//   tone_freq    out  30   {tone2,tone1,tone0}, 10 bits each
//   attenuation  out  16   {att3(noise),att2,att1,att0}, 4 bits each
//   noise_ctrl   out  3    noise control register
//   noise_reset  out  1    one-cycle pulse: noise LFSR must reload
// BEHAVIOUR
//   Reset (async, rst_n=0): tone_freq=0, attenuation=all 4'hF, noise_ctrl=0, noise_reset=0,
//     wr_ready=1, latched channel=0, latched type=tone, FSM=IDLE, busy counter=0.
//   Byte format: latch = 1 cc t dddd (cc channel 0..3, t 1=attenuation/0=tone-or-noise);
//     data = 0 x dddddd (bit 6 ignored).
//   On accept of latch byte: latched_ch<=cc, latched_type<=t, then:
//     t=1            -> attenuation[cc] <= dddd
//     t=0, cc<3      -> tone[cc][3:0] <= dddd, tone[cc][9:4] unchanged
//     t=0, cc=3      -> noise_ctrl <= dddd[2:0]; noise_reset pulses
//   On accept of data byte, using latched_ch/latched_type (latch state unchanged):
//     attenuation    -> attenuation[ch] <= d[3:0]
//     tone, ch<3     -> tone[ch][9:4] <= d[5:0], tone[ch][3:0] unchanged
//     noise (ch=3)   -> noise_ctrl <= d[2:0]; noise_reset pulses
//   Latency: byte accepted in cycle N -> register outputs updated at N+1;
//     noise_reset high exactly in cycle N+1, low otherwise.
//   FSM, wr_ready registered:
//     IDLE (wr_ready=1): on accept, if BUSY_CYCLES>0 -> BUSY, cnt<=BUSY_CYCLES-1, else stay IDLE.
//     BUSY (wr_ready=0): cnt==0 -> IDLE, else cnt<=cnt-1.
//     Net effect: wr_ready low in cycles N+1..N+BUSY_CYCLES, high at N+BUSY_CYCLES+1.
//     BUSY_CYCLES=0: wr_ready constant 1, back-to-back accepts every cycle.
//   wr_valid while wr_ready=0: no register change, byte not queued; host holds it.
//   Writes to the same field overwrite, last-accepted wins; no other field is touched.
//   Reset mid-BUSY or mid-write sequence: immediate return to reset values;
//     pending data-byte context is lost (latch = ch0 tone).
//   Outputs are registered; no combinational path from wr_data to any output.
// TESTING
//   1 Reset: rst_n=0 -> tone_freq=0, attenuation=16'hFFFF, noise_ctrl=0, wr_ready=1.
//   2 Tone: 0x8E then 0x0F (each held until ready) -> tone0=10'h0FE;
//     wr_ready low exactly 32 cycles after each accept.
//   3 Volume: 0xBF -> att1=4'hF; 0xD5 -> att2=4'h5; other fields unchanged.
//   4 Noise: 0xE4 -> noise_ctrl=3'b100, single noise_reset pulse at N+1;
//     then 0x03 -> noise_ctrl=3'b011, second pulse.
//   5 Data after volume latch: 0x90 then 0x47 -> att0=4'h7, tone0 unchanged;
//     wr_valid held during busy is accepted only once.
//   6 Async reset mid-BUSY (10 cycles after accept) -> all outputs at reset values
//     before the next clk edge; wr_ready=1.

Source files
------------

// File: rtl/sn76489_reg_decoder.sv
// SN76489 host write port: decodes latch/data command bytes into the tone,
// attenuation and noise registers, with a READY busy window after each byte.
module sn76489_reg_decoder #(
    parameter int TONE_FREQUENCY_BITS = 10,
    parameter int ATTENUATION_BITS    = 4,
    parameter int NOISE_CONTROL_BITS  = 3,
    parameter int BUSY_CYCLES         = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       wr_data,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    output logic [3*TONE_FREQUENCY_BITS-1:0] tone_freq,
    output logic [4*ATTENUATION_BITS-1:0]    attenuation,
    output logic [NOISE_CONTROL_BITS-1:0]    noise_ctrl,
    output logic                             noise_reset
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam logic [7:0] CNT_INIT = (BUSY_CYCLES > 0) ? 8'(BUSY_CYCLES - 1) : 8'd0;

    logic [2:0][TONE_FREQUENCY_BITS-1:0] tone_q, tone_d;
    logic [3:0][ATTENUATION_BITS-1:0]    att_q, att_d;
    logic [NOISE_CONTROL_BITS-1:0]       noise_q, noise_d;
    logic                                nrst_q, nrst_d;
    logic [1:0]                          lch_q, lch_d;
    logic                                ltype_q, ltype_d;
    logic [0:0]                          state_q, state_d;
    logic [7:0]                          cnt_q, cnt_d;

    logic       ready;
    logic       accept;
    logic [1:0] wr_ch;
    logic       wr_att;
    logic       is_latch;

    assign ready    = (state_q == S_IDLE);
    assign accept   = wr_valid & ready;
    assign is_latch = wr_data[7];
    // Data bytes reuse the channel/type captured by the most recent latch byte.
    assign wr_ch    = is_latch ? wr_data[6:5] : lch_q;
    assign wr_att   = is_latch ? wr_data[4]   : ltype_q;

    always_comb begin
        tone_d  = tone_q;
        att_d   = att_q;
        noise_d = noise_q;
        nrst_d  = 1'b0;
        lch_d   = lch_q;
        ltype_d = ltype_q;
        if (accept) begin
            if (is_latch) begin
                lch_d   = wr_data[6:5];
                ltype_d = wr_data[4];
            end
            if (wr_att) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (wr_ch == 2'(i)) att_d[i] = wr_data[ATTENUATION_BITS-1:0];
                end
            end else if (wr_ch == 2'd3) begin
                noise_d = wr_data[NOISE_CONTROL_BITS-1:0];
                nrst_d  = 1'b1;
            end else begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (wr_ch == 2'(i)) begin
                        if (is_latch) tone_d[i][3:0] = wr_data[3:0];
                        else          tone_d[i][TONE_FREQUENCY_BITS-1:4] = wr_data[5:0];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (BUSY_CYCLES > 0)) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            S_BUSY: begin
                if (cnt_q == 8'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_q  <= '0;
            att_q   <= '1;
            noise_q <= '0;
            nrst_q  <= 1'b0;
            lch_q   <= '0;
            ltype_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            tone_q  <= tone_d;
            att_q   <= att_d;
            noise_q <= noise_d;
            nrst_q  <= nrst_d;
            lch_q   <= lch_d;
            ltype_q <= ltype_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_ready    = ready;
    assign tone_freq   = tone_q;
    assign attenuation = att_q;
    assign noise_ctrl  = noise_q;
    assign noise_reset = nrst_q;

endmodule

// File: tb/tb_sn76489_reg_decoder.sv
// Directed bench for sn76489_reg_decoder: command bytes with hand-computed
// register contents, busy-window length and noise_reset pulse counts.
module tb_sn76489_reg_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [29:0] tone_freq;
    logic [15:0] attenuation;
    logic [2:0]  noise_ctrl;
    logic        noise_reset;

    int checks;
    int failures;
    int busy_n;
    int pulse_n;

    sn76489_reg_decoder #(
        .TONE_FREQUENCY_BITS(10),
        .ATTENUATION_BITS   (4),
        .NOISE_CONTROL_BITS (3),
        .BUSY_CYCLES        (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tone_freq  (tone_freq),
        .attenuation(attenuation),
        .noise_ctrl (noise_ctrl),
        .noise_reset(noise_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the byte until ready, then return 1ns after the accepting edge.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        wr_data  = b;
        wr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    // Counts cycles with wr_ready low and noise_reset pulses from the current cycle on.
    task automatic measure_busy(output int busy, output int pulses);
        busy   = 0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (noise_reset === 1'b1) pulses++;
            if (wr_ready === 1'b1) break;
            busy++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        #12;
        check("rst_tone",  32'(tone_freq),   32'h0);
        check("rst_att",   32'(attenuation), 32'hFFFF);
        check("rst_noise", 32'(noise_ctrl),  32'h0);
        check("rst_ready", 32'(wr_ready),    32'h1);
        check("rst_nrst",  32'(noise_reset), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // tone0 = 0x0FE from latch 0x8E + data 0x0F
        send(8'h8E);
        check("tone_latch", 32'(tone_freq), 32'h00E);
        measure_busy(busy_n, pulse_n);
        check("busy_len_latch", 32'(busy_n), 32'd32);
        send(8'h0F);
        check("tone_data", 32'(tone_freq), 32'h0FE);
        measure_busy(busy_n, pulse_n);
        check("busy_len_data", 32'(busy_n), 32'd32);
        check("tone_no_pulse", 32'(pulse_n), 32'd0);

        // att1 = F, att2 = 5
        send(8'hBF);
        check("att1", 32'(attenuation), 32'hFFFF);
        measure_busy(busy_n, pulse_n);
        send(8'hD5);
        check("att2", 32'(attenuation), 32'hF5FF);
        check("att_tone_kept", 32'(tone_freq), 32'h0FE);
        measure_busy(busy_n, pulse_n);

        // noise latch then noise data, one pulse each
        send(8'hE4);
        check("noise_latch", 32'(noise_ctrl), 32'h4);
        check("nrst_n1", 32'(noise_reset), 32'h1);
        measure_busy(busy_n, pulse_n);
        check("nrst_pulses1", 32'(pulse_n), 32'd1);
        check("nrst_low_after", 32'(noise_reset), 32'h0);
        send(8'h03);
        check("noise_data", 32'(noise_ctrl), 32'h3);
        check("nrst_n1_b", 32'(noise_reset), 32'h1);
        measure_busy(busy_n, pulse_n);
        check("nrst_pulses2", 32'(pulse_n), 32'd1);
        check("noise_att_kept", 32'(attenuation), 32'hF5FF);

        // volume latch ch0, then data byte held through the busy window
        send(8'h90);
        check("att0_latch", 32'(attenuation), 32'hF5F0);
        wr_data  = 8'h47;
        wr_valid = 1'b1;
        repeat (20) @(negedge clk);
        check("held_not_taken", 32'(attenuation), 32'hF5F0);
        send(8'h47);
        check("att0_data", 32'(attenuation), 32'hF5F7);
        check("att0_tone_kept", 32'(tone_freq), 32'h0FE);
        check("att0_noise_kept", 32'(noise_ctrl), 32'h3);
        measure_busy(busy_n, pulse_n);
        check("held_once_busy", 32'(busy_n), 32'd32);
        repeat (3) @(negedge clk);
        check("held_once_ready", 32'(wr_ready), 32'h1);

        // tone2 = 0x3C5 via latch 0xC5 + data 0x7C (bit 6 ignored)
        send(8'hC5);
        measure_busy(busy_n, pulse_n);
        send(8'h7C);
        check("tone2", 32'(tone_freq), 32'({10'h3C5, 10'h000, 10'h0FE}));
        measure_busy(busy_n, pulse_n);

        // async reset 10 cycles into busy
        send(8'hA3);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tone",  32'(tone_freq),   32'h0);
        check("arst_att",   32'(attenuation), 32'hFFFF);
        check("arst_noise", 32'(noise_ctrl),  32'h0);
        check("arst_ready", 32'(wr_ready),    32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        // data byte after reset goes to the default ch0 tone latch
        send(8'h2C);
        check("post_rst_data", 32'(tone_freq), 32'h2C0);
        check("post_rst_att", 32'(attenuation), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
